// File: rtl/fmap_window_reader.sv
// Read-address generator that sweeps every KxK window of a row-major feature map.
// Define WINDOW_READER_PAD_EN for "same" padding with rd_pad flagging out-of-map taps.
module fmap_window_reader #(
  parameter int unsigned IMG_W     = 28,
  parameter int unsigned IMG_H     = 28,
  parameter int unsigned K         = 3,
  parameter int unsigned ADDR_BITS = 10,
  parameter int unsigned TAP_BITS  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [ADDR_BITS-1:0] rd_addr,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic [TAP_BITS-1:0]  tap_idx,
  output logic                 last_tap,
  output logic                 last_win,
  output logic                 rd_pad
);

`ifdef WINDOW_READER_PAD_EN
  localparam int unsigned P  = (K - 1) / 2;
  localparam int unsigned OW = IMG_W;
  localparam int unsigned OH = IMG_H;
  localparam int unsigned SW = ADDR_BITS + 2;
  localparam logic signed [SW-1:0] H_S = SW'(IMG_H);
  localparam logic signed [SW-1:0] W_S = SW'(IMG_W);
  localparam logic signed [SW-1:0] P_S = SW'(P);
`else
  localparam int unsigned P  = 0;
  localparam int unsigned OW = IMG_W - K + 1;
  localparam int unsigned OH = IMG_H - K + 1;
`endif
  localparam int unsigned CW = ADDR_BITS;

  localparam logic [CW-1:0]        K_LAST   = CW'(K - 1);
  localparam logic [CW-1:0]        OW_LAST  = CW'(OW - 1);
  localparam logic [CW-1:0]        OH_LAST  = CW'(OH - 1);
  localparam logic [ADDR_BITS-1:0] ROW_STEP = ADDR_BITS'(IMG_W);
  // Address of pixel (-P,-P); modular wrap is harmless since padded taps force rd_addr to 0.
  localparam logic [ADDR_BITS-1:0] BASE0    = ADDR_BITS'(0) - ADDR_BITS'(P * IMG_W + P);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [CW-1:0]        kc_q, kc_d, kr_q, kr_d, oc_q, oc_d, orow_q, orow_d;
  logic [TAP_BITS-1:0]  tap_q, tap_d;
  // line: window-row origin, win: window origin, row: current tap row start, pix: current tap
  logic [ADDR_BITS-1:0] line_q, line_d, win_q, win_d, row_q, row_d, pix_q, pix_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic                 busy_q, busy_d, done_q, done_d, valid_q, valid_d;
  logic                 last_tap_q, last_tap_d, last_win_q, last_win_d, pad_q, pad_d;
`ifdef WINDOW_READER_PAD_EN
  logic signed [SW-1:0] r_s, c_s;
`endif

  // Next-state: carry chain kc -> kr -> oc -> orow with incremental address bases.
  always_comb begin
    state_d = state_q;
    kc_d    = kc_q;
    kr_d    = kr_q;
    oc_d    = oc_q;
    orow_d  = orow_q;
    tap_d   = tap_q;
    line_d  = line_q;
    win_d   = win_q;
    row_d   = row_q;
    pix_d   = pix_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          kc_d    = '0;
          kr_d    = '0;
          oc_d    = '0;
          orow_d  = '0;
          tap_d   = '0;
          line_d  = BASE0;
          win_d   = BASE0;
          row_d   = BASE0;
          pix_d   = BASE0;
        end
      end
      S_RUN: begin
        if (rd_ready) begin
          if (kc_q != K_LAST) begin
            kc_d  = kc_q + CW'(1);
            tap_d = tap_q + TAP_BITS'(1);
            pix_d = pix_q + ADDR_BITS'(1);
          end else begin
            kc_d = '0;
            if (kr_q != K_LAST) begin
              kr_d  = kr_q + CW'(1);
              tap_d = tap_q + TAP_BITS'(1);
              row_d = row_q + ROW_STEP;
              pix_d = row_q + ROW_STEP;
            end else begin
              kr_d  = '0;
              tap_d = '0;
              if (oc_q != OW_LAST) begin
                oc_d  = oc_q + CW'(1);
                win_d = win_q + ADDR_BITS'(1);
                row_d = win_q + ADDR_BITS'(1);
                pix_d = win_q + ADDR_BITS'(1);
              end else begin
                oc_d = '0;
                if (orow_q != OH_LAST) begin
                  orow_d = orow_q + CW'(1);
                  line_d = line_q + ROW_STEP;
                  win_d  = line_q + ROW_STEP;
                  row_d  = line_q + ROW_STEP;
                  pix_d  = line_q + ROW_STEP;
                end else begin
                  orow_d  = '0;
                  state_d = S_DONE;
                end
              end
            end
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output values derived from the next counter state so they register alongside it.
  always_comb begin
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
    valid_d    = 1'b0;
    last_tap_d = 1'b0;
    last_win_d = 1'b0;
    pad_d      = 1'b0;
    addr_d     = '0;
`ifdef WINDOW_READER_PAD_EN
    r_s = SW'(orow_d) + SW'(kr_d) - P_S;
    c_s = SW'(oc_d) + SW'(kc_d) - P_S;
`endif
    if (state_d == S_RUN) begin
      valid_d    = 1'b1;
      last_tap_d = (kc_d == K_LAST) && (kr_d == K_LAST);
      last_win_d = (oc_d == OW_LAST) && (orow_d == OH_LAST);
`ifdef WINDOW_READER_PAD_EN
      pad_d = (r_s < 0) || (r_s >= H_S) || (c_s < 0) || (c_s >= W_S);
`else
      pad_d = 1'b0;
`endif
      addr_d = pad_d ? '0 : pix_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      kc_q       <= '0;
      kr_q       <= '0;
      oc_q       <= '0;
      orow_q     <= '0;
      tap_q      <= '0;
      line_q     <= '0;
      win_q      <= '0;
      row_q      <= '0;
      pix_q      <= '0;
      addr_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      valid_q    <= 1'b0;
      last_tap_q <= 1'b0;
      last_win_q <= 1'b0;
      pad_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      kc_q       <= kc_d;
      kr_q       <= kr_d;
      oc_q       <= oc_d;
      orow_q     <= orow_d;
      tap_q      <= tap_d;
      line_q     <= line_d;
      win_q      <= win_d;
      row_q      <= row_d;
      pix_q      <= pix_d;
      addr_q     <= addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      valid_q    <= valid_d;
      last_tap_q <= last_tap_d;
      last_win_q <= last_win_d;
      pad_q      <= pad_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign rd_valid = valid_q;
  assign rd_addr  = addr_q;
  assign tap_idx  = tap_q;
  assign last_tap = last_tap_q;
  assign last_win = last_win_q;
  assign rd_pad   = pad_q;

endmodule

// File: tb/tb_fmap_window_reader.sv
// Scoreboard bench for fmap_window_reader: a window/tap reference model fills a queue,
// a negedge monitor pops and compares each accepted tap.
module tb_fmap_window_reader;
  localparam int IMG_W = 28;
  localparam int IMG_H = 28;
  localparam int K     = 3;
  localparam int AB    = 10;
  localparam int TBITS = 4;
`ifdef WINDOW_READER_PAD_EN
  localparam int P  = (K - 1) / 2;
  localparam int OW = IMG_W;
  localparam int OH = IMG_H;
`else
  localparam int P  = 0;
  localparam int OW = IMG_W - K + 1;
  localparam int OH = IMG_H - K + 1;
`endif
  localparam int TOTAL  = OW * OH * K * K;
  localparam int BUDGET = 40000;

  typedef struct packed {
    logic [AB-1:0]    addr;
    logic [TBITS-1:0] tap;
    logic             lt;
    logic             lw;
    logic             pad;
  } tap_t;

  logic             clk, rst, start, rd_ready;
  logic             busy, done, rd_valid, last_tap, last_win, rd_pad;
  logic [AB-1:0]    rd_addr;
  logic [TBITS-1:0] tap_idx;

  tap_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   acc_cnt = 0;
  int   done_cnt = 0;
  int   cyc = 0;
  int   last_acc_cyc = -10;
  bit   rand_ready = 1'b0;
  bit   stalled = 1'b0;
  logic [18:0] held;

  fmap_window_reader #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .ADDR_BITS(AB), .TAP_BITS(TBITS)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .tap_idx(tap_idx), .last_tap(last_tap), .last_win(last_win), .rd_pad(rd_pad)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    rd_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference: enumerate windows and taps directly with plain arithmetic.
  task automatic push_sweep();
    tap_t t;
    int r, c;
    exp_q.delete();
    for (int orow = 0; orow < OH; orow++)
      for (int oc = 0; oc < OW; oc++)
        for (int kr = 0; kr < K; kr++)
          for (int kc = 0; kc < K; kc++) begin
            r     = orow + kr - P;
            c     = oc + kc - P;
            t.pad = (r < 0) || (r >= IMG_H) || (c < 0) || (c >= IMG_W);
            t.addr = t.pad ? '0 : AB'(r * IMG_W + c);
            t.tap  = TBITS'(kr * K + kc);
            t.lt   = (kr == K - 1) && (kc == K - 1);
            t.lw   = (orow == OH - 1) && (oc == OW - 1);
            exp_q.push_back(t);
          end
  endtask

  // Monitor: compares accepted taps, checks stability under stall, times done.
  always @(negedge clk) begin
    logic [18:0] cur;
    tap_t e;
    cur = {rd_valid, busy, rd_addr, tap_idx, last_tap, last_win, rd_pad};
    if (rst) begin
      stalled = 1'b0;
    end else begin
      if (stalled) chk("hold_while_stalled", 64'(cur), 64'(held));
      if (rd_valid && rd_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_tap", 64'(cur), 64'(0));
        end else begin
          e = exp_q.pop_front();
          chk("tap", 64'(cur), 64'({1'b1, 1'b1, e}));
        end
        acc_cnt++;
        if (last_tap && last_win) last_acc_cyc = cyc;
        stalled = 1'b0;
      end else if (rd_valid) begin
        held    = cur;
        stalled = 1'b1;
      end else begin
        stalled = 1'b0;
      end
      if (done) begin
        done_cnt++;
        chk("done_timing", 64'(cyc), 64'(last_acc_cyc + 1));
      end
    end
  end

  task automatic issue_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("start_latency_valid", 64'(rd_valid), 64'(1));
  endtask

  task automatic run_sweep(input bit rnd, input int pulse_at);
    bit pulsed = 1'b0;
    bit seen   = 1'b0;
    rand_ready = rnd;
    push_sweep();
    acc_cnt  = 0;
    done_cnt = 0;
    issue_start();
    for (int i = 0; i < BUDGET; i++) begin
      @(posedge clk);
      #1;
      if (pulse_at >= 0 && !pulsed && acc_cnt >= pulse_at) begin
        start  = 1'b1;
        pulsed = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done_cnt > 0) begin
        seen = 1'b1;
        break;
      end
    end
    start = 1'b0;
    if (!seen) chk("sweep_timeout", 64'(0), 64'(1));
    repeat (3) @(posedge clk);
    #1;
    chk("accept_count", 64'(acc_cnt), 64'(TOTAL));
    chk("done_count", 64'(done_cnt), 64'(1));
    chk("queue_empty", 64'(exp_q.size()), 64'(0));
    chk("idle_after_done", 64'({busy, rd_valid}), 64'(0));
  endtask

  task automatic abort_sweep();
    bit hit = 1'b0;
    rand_ready = 1'b1;
    push_sweep();
    acc_cnt  = 0;
    done_cnt = 0;
    issue_start();
    for (int i = 0; i < BUDGET; i++) begin
      @(posedge clk);
      #1;
      if (acc_cnt >= 10 * K * K + 3) begin
        hit = 1'b1;
        break;
      end
    end
    if (!hit) chk("abort_reach_timeout", 64'(0), 64'(1));
    rst = 1'b1;
    @(negedge clk);
    chk("abort_outputs_zero",
        64'({busy, done, rd_valid, rd_addr, tap_idx, last_tap, last_win, rd_pad}), 64'(0));
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("abort_no_done", 64'(done_cnt), 64'(0));
    chk("abort_stays_idle", 64'({busy, rd_valid}), 64'(0));
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    rd_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs",
        64'({busy, done, rd_valid, rd_addr, tap_idx, last_tap, last_win, rd_pad}), 64'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("idle_no_valid", 64'({busy, rd_valid}), 64'(0));

    run_sweep(1'b0, -1);
    run_sweep(1'b1, 100);
    abort_sweep();
    run_sweep(1'b1, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
